// File: rtl/cbx_param.sv
// Connection box: chanx feed-throughs plus configurable ipin muxes loaded from a serial chain.
// Define CBX_CFG_CHECK_EN to gate each commit on an exact chain-length count.
module cbx_param #(
  parameter int CHAN_W       = 20,
  parameter int N_IPIN       = 12,
  parameter int MUX_SIZE     = 10,
  parameter int TRACK_STRIDE = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              config_enable,
  input  logic              ccff_head,
  input  logic [CHAN_W-1:0] chanx_left_in,
  input  logic [CHAN_W-1:0] chanx_right_in,
  output logic [CHAN_W-1:0] chanx_left_out,
  output logic [CHAN_W-1:0] chanx_right_out,
  output logic [N_IPIN-1:0] ipin_out,
  output logic              ccff_tail,
  output logic              cfg_committed,
  output logic              cfg_err
);

  localparam int SEL_W    = $clog2(MUX_SIZE);
  localparam int CFG_BITS = N_IPIN * SEL_W;

  logic [CFG_BITS-1:0]           chain_q, chain_d;
  logic [N_IPIN-1:0][SEL_W-1:0]  sel_q, sel_d;
  logic [N_IPIN-1:0][SEL_W-1:0]  chain_sel;
  logic                          en_q;
  logic                          commit_req;
  logic                          commit;

  assign chanx_right_out = chanx_left_in;
  assign chanx_left_out  = chanx_right_in;
  assign ccff_tail       = chain_q[CFG_BITS-1];
  assign commit_req      = en_q & ~config_enable;

  // Each ipin field sits MSB-first in the chain, so reverse it into a select.
  for (genvar k = 0; k < N_IPIN; k++) begin : g_ipin
    logic [MUX_SIZE-1:0] mux_in;

    for (genvar j = 0; j < SEL_W; j++) begin : g_bit
      assign chain_sel[k][SEL_W-1-j] = chain_q[k*SEL_W+j];
    end

    for (genvar m = 0; m < MUX_SIZE/2; m++) begin : g_pair
      localparam int IDX = (k + m*TRACK_STRIDE) % CHAN_W;
      assign mux_in[2*m]   = chanx_left_in[IDX];
      assign mux_in[2*m+1] = chanx_right_in[IDX];
    end

    assign ipin_out[k] = (int'(sel_q[k]) < MUX_SIZE) ?
                         mux_in[sel_q[k]] : 1'b0;
  end

`ifdef CBX_CFG_CHECK_EN
  localparam int CNT_W = $clog2(CFG_BITS + 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             cnt_ok;

  assign cnt_ok = (cnt_q == CNT_W'(CFG_BITS));
  assign commit = commit_req & cnt_ok;

  // The rising-edge cycle is itself a shift, so the count restarts at 1.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | (commit_req & ~cnt_ok);
    if (config_enable) begin
      if (!en_q)
        cnt_d = CNT_W'(1);
      else if (cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cfg_err = err_q;
`else
  assign commit  = commit_req;
  assign cfg_err = 1'b0;
`endif

  assign cfg_committed = commit & ~pReset;

  always_comb begin
    chain_d = chain_q;
    sel_d   = sel_q;
    if (config_enable)
      chain_d = {chain_q[CFG_BITS-2:0], ccff_head};
    if (commit)
      sel_d = chain_sel;
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      chain_q <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      chain_q <= chain_d;
      sel_q   <= sel_d;
      en_q    <= config_enable;
    end
  end

endmodule

// File: tb/tb_cbx_param.sv
// Directed bench for cbx_param at default parameters.
// Length-check cases follow CBX_CFG_CHECK_EN.
module tb_cbx_param;

  logic        prog_clk = 1'b0;
  logic        pReset;
  logic        config_enable;
  logic        ccff_head;
  logic [19:0] chanx_left_in;
  logic [19:0] chanx_right_in;
  logic [19:0] chanx_left_out;
  logic [19:0] chanx_right_out;
  logic [11:0] ipin_out;
  logic        ccff_tail;
  logic        cfg_committed;
  logic        cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0][3:0] sels;
  logic [47:0]      img;

  cbx_param dut (
    .prog_clk        (prog_clk),
    .pReset          (pReset),
    .config_enable   (config_enable),
    .ccff_head       (ccff_head),
    .chanx_left_in   (chanx_left_in),
    .chanx_right_in  (chanx_right_in),
    .chanx_left_out  (chanx_left_out),
    .chanx_right_out (chanx_right_out),
    .ipin_out        (ipin_out),
    .ccff_tail       (ccff_tail),
    .cfg_committed   (cfg_committed),
    .cfg_err         (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  function automatic logic [47:0] mk_img(input logic [11:0][3:0] s);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < 12; k++)
      for (int j = 0; j < 4; j++)
        r[k*4+j] = s[k][3-j];
    return r;
  endfunction

  task automatic shift_bits(input logic [47:0] im, input int n);
    config_enable = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      ccff_head = im[i];
      tick();
    end
    ccff_head = 1'b0;
  endtask

  task automatic do_reset();
    pReset        = 1'b1;
    config_enable = 1'b0;
    tick();
    pReset = 1'b0;
    #1;
  endtask

  initial begin
    pReset         = 1'b0;
    config_enable  = 1'b0;
    ccff_head      = 1'b0;
    chanx_left_in  = 20'h00001;
    chanx_right_in = 20'h00000;
    do_reset();

    chk("rst_ipin", ipin_out, 12'h001);
    chk("rst_tail", ccff_tail, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_commit", cfg_committed, 1'b0);
    chanx_left_in  = 20'h12AA5;
    chanx_right_in = 20'h5A5A5;
    #1;
    chk("rst_sel0", ipin_out, 12'hAA5);
    chk("feed_r", chanx_right_out, 20'h12AA5);
    chk("feed_l", chanx_left_out, 20'h5A5A5);

    // Load ipin0=5 (right[4]) and ipin11=1 (right[11]) while channels churn
    sels     = '0;
    sels[0]  = 4'd5;
    sels[11] = 4'd1;
    img      = mk_img(sels);
    config_enable = 1'b1;
    for (int i = 47; i >= 0; i--) begin
      ccff_head      = img[i];
      chanx_left_in  = 20'($urandom);
      chanx_right_in = 20'($urandom);
      #1;
      if (i == 40 || i == 20)
        chk("shift_old_sel", ipin_out, chanx_left_in[11:0]);
      if (i == 0)
        chk("tail_47", ccff_tail, 1'b0);
      tick();
    end
    chk("tail_48", ccff_tail, 1'b1);
    chanx_left_in  = 20'hFFFFF;
    chanx_right_in = 20'h00000;
    #1;
    chk("pre_commit", ipin_out, 12'hFFF);
    config_enable = 1'b0;
    #1;
    chk("commit_pulse", cfg_committed, 1'b1);
    chk("commit_same", ipin_out, 12'hFFF);
    tick();
    chk("pulse_end", cfg_committed, 1'b0);
    chk("new_sel_a", ipin_out, 12'h7FE);
    chanx_left_in  = 20'h00000;
    chanx_right_in = 20'h00010;
    #1;
    chk("new_sel_b", ipin_out, 12'h001);
    chanx_right_in = 20'h00800;
    #1;
    chk("new_sel_c", ipin_out, 12'h800);
    tick();
    chk("tail_hold", ccff_tail, 1'b1);

    // ipin0=8, ipin1=9 (max legal), ipin2=10, ipin3=15, ipin10=9
    sels     = '0;
    sels[0]  = 4'd8;
    sels[1]  = 4'd9;
    sels[2]  = 4'd10;
    sels[3]  = 4'd15;
    sels[10] = 4'd9;
    shift_bits(mk_img(sels), 48);
    config_enable = 1'b0;
    tick();
    chanx_left_in  = 20'hFFFFF;
    chanx_right_in = 20'hFFFFF;
    #1;
    chk("range_all1", ipin_out, 12'hFF3);
    chanx_left_in = 20'h00000;
    #1;
    chk("range_right", ipin_out, 12'h402);
    chanx_left_in  = 20'hFFFFF;
    chanx_right_in = 20'h00000;
    #1;
    chk("range_left", ipin_out, 12'hBF1);
    chanx_left_in  = 20'h00000;
    chanx_right_in = 20'h40000;
    #1;
    chk("range_r18", ipin_out, 12'h400);

    // Reset mid-shift must abort without commit
    do_reset();
    shift_bits({48{1'b1}}, 20);
    pReset = 1'b1;
    tick();
    pReset        = 1'b0;
    config_enable = 1'b0;
    #1;
    chk("abort_commit", cfg_committed, 1'b0);
    tick();
    chanx_left_in  = 20'hFFFFF;
    chanx_right_in = 20'h00000;
    #1;
    chk("abort_sel_l", ipin_out, 12'hFFF);
    chanx_left_in  = 20'h00000;
    chanx_right_in = 20'hFFFFF;
    #1;
    chk("abort_sel_r", ipin_out, 12'h000);

    // Reset coinciding with the enable drop
    shift_bits({48{1'b1}}, 48);
    config_enable = 1'b0;
    pReset        = 1'b1;
    #1;
    chk("rst_vs_commit", cfg_committed, 1'b0);
    tick();
    pReset = 1'b0;
    #1;
    chk("rst_vs_commit2", cfg_committed, 1'b0);
    chk("rst_vs_tail", ccff_tail, 1'b0);

    sels    = '0;
    sels[0] = 4'd5;
    img     = mk_img(sels);
    do_reset();
`ifdef CBX_CFG_CHECK_EN
    shift_bits(img, 47);
    config_enable = 1'b0;
    #1;
    chk("short_commit", cfg_committed, 1'b0);
    tick();
    chk("short_err", cfg_err, 1'b1);
    chanx_left_in  = 20'hFFFFF;
    chanx_right_in = 20'h00000;
    #1;
    chk("short_hold", ipin_out, 12'hFFF);
    shift_bits(img, 48);
    config_enable = 1'b0;
    #1;
    chk("full_commit", cfg_committed, 1'b1);
    chk("full_err", cfg_err, 1'b1);
    tick();
    chanx_left_in  = 20'h00000;
    chanx_right_in = 20'h00010;
    #1;
    chk("full_sel", ipin_out, 12'h001);
    config_enable = 1'b1;
    tick();
    config_enable = 1'b0;
    #1;
    chk("pulse_commit", cfg_committed, 1'b0);
    tick();
    chk("pulse_err", cfg_err, 1'b1);
`else
    shift_bits(img, 47);
    config_enable = 1'b0;
    #1;
    chk("short_commit", cfg_committed, 1'b1);
    chk("short_err", cfg_err, 1'b0);
    tick();
    config_enable = 1'b1;
    tick();
    config_enable = 1'b0;
    #1;
    chk("pulse_commit", cfg_committed, 1'b1);
    tick();
    chk("pulse_err", cfg_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cbx_param.md
CBX_PARAM -- requirements
Module: cbx_param

Interface
REQ-001 Parameter CHAN_W, default 20: tracks per direction on each chanx side.
REQ-002 Parameter N_IPIN, default 12: grid input pins driven.
REQ-003 Parameter MUX_SIZE, default 10, even, at least 2: inputs per ipin mux.
REQ-004 Parameter TRACK_STRIDE, default 2: track spacing between mux input pairs.
REQ-005 Derived values: SEL_W = clog2(MUX_SIZE); CFG_BITS = N_IPIN*SEL_W; CNT_W = clog2(CFG_BITS+2).
REQ-006 Ports, one per line:
- prog_clk  in  1  configuration clock; one clock only.
- pReset  in  1  reset, synchronous, active-high.
- config_enable  in  1  chain shift enable.
- ccff_head  in  1  chain serial input.
- chanx_left_in  in  CHAN_W  left tracks.
- chanx_right_in  in  CHAN_W  right tracks.
- chanx_left_out  out  CHAN_W  feed-through from chanx_right_in.
- chanx_right_out  out  CHAN_W  feed-through from chanx_left_in.
- ipin_out  out  N_IPIN  mux outputs to the grid.
- ccff_tail  out  1  chain serial output.
- cfg_committed  out  1  one-cycle commit pulse.
- cfg_err  out  1  sticky length-error flag.

Function
REQ-007 The feed-throughs SHALL be combinational: chanx_right_out[t] = chanx_left_in[t] and chanx_left_out[t] = chanx_right_in[t].
REQ-008 The shift chain SHALL be a CFG_BITS-bit register. On each prog_clk edge with config_enable=1: chain[0] <= ccff_head, chain[i] <= chain[i-1], ccff_tail = chain[CFG_BITS-1].
REQ-009 Serial order SHALL be ipin N_IPIN-1 first, LSB first, through ipin 0, with its MSB last. Ipin k field = chain[k*SEL_W +: SEL_W], chain[k*SEL_W] is the MSB.
REQ-010 The block SHALL register en_d = config_enable each cycle.
REQ-011 A commit SHALL occur in the cycle where en_d=1 and config_enable=0.
REQ-012 On commit, the active select register (N_IPIN x SEL_W) SHALL load from the chain and cfg_committed SHALL pulse for that same cycle.
REQ-013 ipin_out SHALL follow the active select combinationally; new selects become visible the cycle after the commit edge.
REQ-014 The chain SHALL hold its contents when config_enable=0; active selects SHALL never change while shifting.
REQ-015 Mux input 2m SHALL be chanx_left_in[(k + m*TRACK_STRIDE) mod CHAN_W] and input 2m+1 SHALL be chanx_right_in[the same index], for m = 0..MUX_SIZE/2-1.
REQ-016 A select value of MUX_SIZE or more SHALL drive ipin_out[k] = 0.
REQ-017 If config_enable rises and falls on consecutive cycles, that SHALL count as one shift followed by a commit.

Reset
REQ-018 With pReset=1 at a prog_clk edge, the following SHALL clear to 0: chain, active selects, en_d, bit counter, cfg_committed, cfg_err. ipin_out[k] SHALL then equal chanx_left_in[k mod CHAN_W].
REQ-019 Reset SHALL take priority over shift and commit. Reset during shifting SHALL abort with no commit, even if config_enable is low in the next cycle.

Configuration
REQ-020 Macro CBX_CFG_CHECK_EN defined: a CNT_W-bit counter SHALL clear when config_enable rises (en_d=0, config_enable=1), increment per shift, and saturate at all-ones.
REQ-021 With the macro defined, a commit SHALL apply only when count == CFG_BITS; otherwise the active selects SHALL hold, cfg_committed SHALL stay 0, and cfg_err SHALL set. cfg_err clears only on reset.
REQ-022 Macro undefined: no counter; every commit SHALL apply; cfg_err SHALL be tied 0.

Verification
REQ-023 Reset with chanx_left_in=20'h00001 -> ipin_out[0]=1, all other ipin_out=0, ccff_tail=0, cfg_err=0.
REQ-024 Shift 48 bits with ipin0=4'b0101 and the rest 0, then drop enable -> cfg_committed for 1 cycle; ipin_out[0] tracks chanx_right_in[4] from the next cycle.
REQ-025 Shift with ipin3=4'b1111 (out of range) -> after commit, ipin_out[3]=0 for any channel value.
REQ-026 During a 48-bit shift, toggle all chanx inputs -> ipin_out follows the old selects until commit; ccff_tail shows the first-shifted bit after 48 shifts.
REQ-027 CBX_CFG_CHECK_EN on, shift 47 bits then drop enable -> no commit, cfg_err=1; a following 48-bit shift commits with cfg_err still 1.
REQ-028 pReset asserted after 20 shifts, then config_enable low -> no cfg_committed, selects stay 0.
